// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_types_pkg
// Purpose  : Shared CPU types for the instruction cache: word type, address
//            decode layout and frame layout at the default 16-frame geometry.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

  localparam int WORD_W = 32;
  localparam int IIDX_W = 4;
  localparam int ITAG_W = WORD_W - IIDX_W - 2;

  typedef logic [WORD_W-1:0] word_t;

  // Instruction address decode: tag | index | byte offset
  typedef struct packed {
    logic [ITAG_W-1:0] tag;
    logic [IIDX_W-1:0] idx;
    logic [1:0]        bytoff;
  } icachef_t;

  // One direct-mapped frame
  typedef struct packed {
    logic              valid;
    logic [ITAG_W-1:0] tag;
    word_t             data;
  } icache_frame_t;

endpackage
`default_nettype wire

// File: rtl/icache_dm.sv
`default_nettype none
// ============================================================================
// Module   : icache_dm
// Purpose  : Direct-mapped, one-word-per-frame instruction cache with a
//            two-state (IDLE/FETCH) miss handler.
// Ports    : CLK, RST         - clock, synchronous active-high reset
//            imemREN/imemaddr - datapath read request and byte address
//            ihit/imemload    - hit flag and instruction word (zero-cycle hit)
//            iREN/iaddr       - memory read request and word address
//            iwait/iload      - memory busy flag and returned data
// Revision : 1.0 - initial release
// ============================================================================
module icache_dm
  import cpu_types_pkg::*;
#(
  parameter int NSETS = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);

  localparam int IDX_W = $clog2(NSETS);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t            state;
  state_t            next_state;

  logic [NSETS-1:0]  valid;
  logic [TAG_W-1:0]  tags  [NSETS];
  word_t             datas [NSETS];
  word_t             miss_addr;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [IDX_W-1:0]  miss_idx;
  logic [TAG_W-1:0]  miss_tag;
  logic              lookup_hit;
  logic              fill;

  // Byte offsets carry no information for word fetches.
  logic unused_bits;
  assign unused_bits = ^{imemaddr[1:0], miss_addr[1:0]};

  assign idx      = imemaddr[IDX_W+1:2];
  assign tag      = imemaddr[31:IDX_W+2];
  assign miss_idx = miss_addr[IDX_W+1:2];
  assign miss_tag = miss_addr[31:IDX_W+2];

  assign lookup_hit = imemREN & valid[idx] & (tags[idx] == tag);
  assign fill       = (state == FETCH) & ~iwait;

  // State, valid bits and miss register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      valid     <= '0;
      miss_addr <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && imemREN && !lookup_hit) begin
        miss_addr <= imemaddr;
      end
      if (fill) begin
        valid[miss_idx] <= 1'b1;
      end
    end
  end

  // Tag/data storage needs no reset; a fill in a reset cycle is discarded.
  always_ff @(posedge CLK) begin
    if (!RST && fill) begin
      tags[miss_idx]  <= miss_tag;
      datas[miss_idx] <= iload;
    end
  end

  // Next state and outputs. Outputs are forced quiet while RST is high so
  // that a reset arriving mid-fetch never presents a request or a hit.
  always_comb begin
    next_state = state;
    ihit       = 1'b0;
    iREN       = 1'b0;
    iaddr      = '0;
    imemload   = datas[idx];
    case (state)
      IDLE: begin
        ihit = lookup_hit & ~RST;
        if (imemREN && !lookup_hit) begin
          next_state = FETCH;
        end
      end
      FETCH: begin
        iREN  = ~RST;
        iaddr = RST ? 32'd0 : {miss_addr[31:2], 2'b00};
        if (!iwait) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: doc/icache_dm.md
ICACHE_DM -- requirements
Module: icache_dm

Interface
REQ-001 SHALL have parameter NSETS, default 16, number of direct-mapped one-word frames (power of two).
REQ-002 SHALL have port CLK  input  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have port RST  input  1  synchronous, active-high reset, sampled on CLK rising edge.
REQ-004 SHALL have port imemREN  input  1  datapath instruction read request.
REQ-005 SHALL have port imemaddr  input  32  datapath instruction byte address (word_t).
REQ-006 SHALL have port ihit  output  1  requested instruction valid this cycle.
REQ-007 SHALL have port imemload  output  32  instruction word, valid when ihit=1.
REQ-008 SHALL have port iREN  output  1  memory read request toward memory controller.
REQ-009 SHALL have port iaddr  output  32  memory read word address.
REQ-010 SHALL have port iwait  input  1  memory busy; iload valid in a cycle with iREN=1 and iwait=0.
REQ-011 SHALL have port iload  input  32  memory read data.

Function
REQ-012 Address split SHALL be: bits [1:0] byte offset (ignored), [log2(NSETS)+1:2] index, remaining upper bits tag (26 bits at NSETS=16).
REQ-013 Each frame SHALL hold valid (1), tag, data (32).
REQ-014 FSM states SHALL be IDLE and FETCH only.
REQ-015 IDLE: ihit SHALL be combinational = imemREN & frame[index].valid & (frame[index].tag == addr tag); imemload = frame[index].data; zero-cycle hit latency.
REQ-016 IDLE with imemREN=1 and no hit SHALL latch imemaddr into a miss register and go to FETCH on the next edge; ihit=0 that cycle.
REQ-017 FETCH: iREN SHALL be 1 and iaddr SHALL be the latched miss address with bits [1:0] forced to 0; ihit SHALL be 0.
REQ-018 FETCH with iwait=0: frame at latched index SHALL be written (valid=1, latched tag, iload) at that edge, FSM to IDLE.
REQ-019 FETCH with iwait=1 SHALL hold state, iREN and iaddr unchanged.
REQ-020 Miss penalty SHALL be memory latency + 1 cycle: hit asserted the first IDLE cycle after fill if imemaddr unchanged.
REQ-021 imemREN deassert or imemaddr change during FETCH SHALL NOT abort the fill; after return to IDLE the current imemaddr is looked up fresh.
REQ-022 A fill SHALL overwrite any valid frame at that index (no replacement choice).
REQ-023 In IDLE, iREN SHALL be 0 and iaddr SHALL be 0.
REQ-024 imemREN=0 in IDLE SHALL hold state, ihit=0, no memory request.

Reset
REQ-025 RST=1 at an edge SHALL clear all valid bits, miss register, and force IDLE; tags/data need not be cleared.
REQ-026 During and after reset: ihit=0, iREN=0, iaddr=0; imemload value don't-care.
REQ-027 RST asserted mid-FETCH SHALL drop iREN on the following cycle and discard the pending fill, even if iwait=0 in the reset cycle.

Structure
REQ-028 cpu_types_pkg SHALL gain ITAG_W, IIDX_W constants, icachef_t packed struct (tag, idx, bytoff) for address decode, and icache_frame_t (valid, tag, data).
REQ-029 FSM state enum SHALL be local to icache_dm.
REQ-030 No sub-module; frame array, FSM and miss register live in icache_dm, sized 120-250 lines.
REQ-031 Datapath-side ports SHALL connect via the datapath_cache_if icache modport; memory-side via the cache_control_if icache-facing signals.

Verification
REQ-032 Cold miss: reset, imemaddr=0x00000040, imemREN=1, memory iwait=1 for 2 cycles then iload=0x8C010004 -> iREN=1 iaddr=0x40 for 3 cycles, ihit=1 imemload=0x8C010004 cycle after fill.
REQ-033 Hit: repeat 0x00000040 -> ihit=1 same cycle, iREN stays 0.
REQ-034 Conflict: 0x00000040 then 0x00000080... select same index 0x00000000 vs 0x00000040 at NSETS=16 (index bits [5:2]: use 0x00000004 and 0x00000044) -> second evicts first; re-reading 0x00000004 misses.
REQ-035 Address change mid-FETCH: miss on 0x100, switch imemaddr to 0x200 during iwait=1 -> fill writes 0x100 frame, then new miss on 0x200, no hit reported for 0x200 with 0x100 data.
REQ-036 Reset mid-FETCH with iwait=0 same cycle -> iREN=0 next cycle, 0x100 lookup afterwards misses.
REQ-037 imemREN=0 with any address -> ihit=0, iREN=0 for 10 cycles.
